// File: rtl/loader_pkg.sv
// Shared definitions for the data_loader frame sequencer.
// Contents:
//   CTRL_*        ctrl_logic encodings understood by data_loader
//   seq_state_t   frame sequencer FSM states
//   frame_len()   cycles per load frame (sync + dim bytes + elements + tail)
package loader_pkg;

    localparam logic [1:0] CTRL_LOAD_DATA = 2'd0;
    localparam logic [1:0] CTRL_LOAD_DIM  = 2'd1;
    localparam logic [1:0] CTRL_IDLE      = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DIM,
        ST_DATA,
        ST_TAIL
    } seq_state_t;

    function automatic int frame_len(input int dim_bytes, input int mat_size);
        return 2 + dim_bytes + 2 * mat_size;
    endfunction

endpackage

// File: rtl/loader_frame_sequencer_if.sv
// Host byte stream plus data_loader drive signals for the frame sequencer.
// Ports (signals):
//   in_data/in_valid/in_ready  host element byte stream (valid/ready)
//   mat_dim                    matrix dimension, sampled at frame start
//   data_send/ctrl_logic       byte and control code to data_loader
//   busy/frame_done            frame in progress / last-cycle pulse
// Modports: master = host/loader side, slave = sequencer.
interface loader_frame_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mat_dim;
    logic [DATA_W-1:0] data_send;
    logic [1:0]        ctrl_logic;
    logic              busy;
    logic              frame_done;

    modport master (
        output in_data, in_valid, mat_dim,
        input  in_ready, data_send, ctrl_logic, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid, mat_dim,
        output in_ready, data_send, ctrl_logic, busy, frame_done
    );
endinterface

// File: rtl/loader_frame_sequencer_byte_fifo.sv
// Synchronous element-byte FIFO with occupancy count.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes FIFO)
//   push, din         write din when push and not full
//   pop, dout         dout is the head; pop advances it when not empty
//   full, empty       occupancy flags
//   count             occupancy, log2(FIFO_DEPTH)+1 bits
module byte_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             din,
    input  logic                          pop,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/loader_frame_sequencer.sv
// Frame sequencer in front of data_loader. Buffers host element bytes and
// emits one fixed-length load frame per matrix pair once every element of
// the frame is already buffered, so the data phase never stalls.
// Ports:
//   CLK   clock, rising edge
//   RST   synchronous active-high reset; abandons any frame, flushes FIFO
//   bus   loader_frame_sequencer_if.slave (host stream + data_loader drive)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a full frame of elements, ctrl=IDLE
// SYNC    | frame cycle 0, ctrl=IDLE, mat_dim captured into dim_q
// DIM     | frame cycles 1..DIM_BYTES, ctrl=LOAD_DIM, data=dim_q
// DATA    | 2*MAT_SIZE cycles, ctrl=LOAD_DATA, data=FIFO head (A then B)
// TAIL    | last frame cycle, ctrl=IDLE, frame_done pulse
module loader_frame_sequencer
    import loader_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAT_SIZE   = 4,
    parameter int DIM_BYTES  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    loader_frame_sequencer_if.slave  bus
);
    localparam int FRAME_LEN = frame_len(DIM_BYTES, MAT_SIZE);
    localparam int CYC_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] FRAME_ELEMS = CNT_W'(2 * MAT_SIZE);
    localparam logic [CYC_W-1:0] LAST_DIM    = CYC_W'(DIM_BYTES);
    localparam logic [CYC_W-1:0] LAST_DATA   = CYC_W'(DIM_BYTES + 2 * MAT_SIZE);

    seq_state_t        state;
    logic [CYC_W-1:0]  cyc;
    logic [DATA_W-1:0] dim_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        ctrl_q;
    logic              busy_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic              frame_ready;

    // No bypass: a full FIFO refuses the byte even if it pops this cycle.
    assign in_ready    = !RST && !fifo_full;
    assign push        = bus.in_valid && in_ready;
    assign frame_ready = (fifo_count >= FRAME_ELEMS);

    // Pop on the edge that loads the head into data_send, i.e. the edge
    // entering each DATA cycle.
    assign pop = ((state == ST_DIM  && cyc == LAST_DIM) ||
                  (state == ST_DATA && cyc != LAST_DATA)) && !fifo_empty;

    byte_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (bus.in_data),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            cyc    <= '0;
            dim_q  <= '0;
            ctrl_q <= CTRL_IDLE;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                // TAIL shares the start decision so frames can run back to back.
                ST_IDLE, ST_TAIL: begin
                    cyc    <= '0;
                    ctrl_q <= CTRL_IDLE;
                    data_q <= '0;
                    if (frame_ready) begin
                        state  <= ST_SYNC;
                        dim_q  <= bus.mat_dim;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    state  <= ST_DIM;
                    cyc    <= cyc + 1'b1;
                    ctrl_q <= CTRL_LOAD_DIM;
                    data_q <= dim_q;
                end
                ST_DIM: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == LAST_DIM) begin
                        state  <= ST_DATA;
                        ctrl_q <= CTRL_LOAD_DATA;
                        data_q <= fifo_head;
                    end else begin
                        ctrl_q <= CTRL_LOAD_DIM;
                        data_q <= dim_q;
                    end
                end
                ST_DATA: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == LAST_DATA) begin
                        state  <= ST_TAIL;
                        ctrl_q <= CTRL_IDLE;
                        data_q <= '0;
                        done_q <= 1'b1;
                    end else begin
                        ctrl_q <= CTRL_LOAD_DATA;
                        data_q <= fifo_head;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.data_send  = data_q;
    assign bus.ctrl_logic = ctrl_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_loader_frame_sequencer.sv
module tb_loader_frame_sequencer;
    import loader_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    loader_frame_sequencer_if #(.DATA_W(8)) bus ();

    loader_frame_sequencer #(
        .DATA_W     (8),
        .MAT_SIZE   (4),
        .DIM_BYTES  (4),
        .FIFO_DEPTH (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [7:0] data;
        logic       done;
        logic       first;
        logic       gapless;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected 14-cycle frame: sync, 4 dim bytes, 8 elements, tail.
    task automatic queue_frame(input int dim, input int base, input int step, input bit gapless);
        exp_q.push_back('{ctrl: 2'd2, data: 8'h00, done: 1'b0, first: 1'b1, gapless: gapless});
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{ctrl: 2'd1, data: 8'(dim), done: 1'b0, first: 1'b0, gapless: 1'b0});
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{ctrl: 2'd0, data: 8'(base + step * i), done: 1'b0, first: 1'b0, gapless: 1'b0});
        exp_q.push_back('{ctrl: 2'd2, data: 8'h00, done: 1'b1, first: 1'b0, gapless: 1'b0});
    endtask

    // Streams n bytes with in_valid held high; returns #1 after the last accepting edge.
    task automatic push_bytes(input int base, input int step, input int n);
        bit rdy;
        int waits;
        bus.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_data = 8'(base + step * i);
            waits = 0;
            forever begin
                @(negedge CLK);
                rdy = bus.in_ready;
                @(posedge CLK);
                #1;
                if (rdy) break;
                waits++;
                if (waits > 200) begin
                    chk("push_timeout", 0, 1);
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int t = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.busy) break;
            t++;
            if (t > 100) begin
                chk("busy_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge CLK);
            t++;
        end
        chk("drain_timeout", (exp_q.size() == 0) ? 1 : 0, 1);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every busy cycle consumes one expected frame cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_cycle", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_ctrl", int'(bus.ctrl_logic), int'(e.ctrl));
                    chk("frame_data", int'(bus.data_send), int'(e.data));
                    chk("frame_done", int'(bus.frame_done), int'(e.done));
                    if (e.first)
                        chk("frame_gapless", int'(prev_busy), int'(e.gapless));
                end
            end else begin
                chk("idle_ctrl", int'(bus.ctrl_logic), 2);
                chk("idle_data", int'(bus.data_send), 0);
                chk("idle_done", int'(bus.frame_done), 0);
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.mat_dim  = 8'd2;

        // Reset
        repeat (3) @(posedge CLK);
        mon_en = 1'b1;
        @(negedge CLK);
        chk("rst_ctrl", int'(bus.ctrl_logic), 2);
        chk("rst_data", int'(bus.data_send), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.frame_done), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        RST = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge CLK);
        #1;

        // Single frame, 0x11..0x88
        queue_frame(2, 8'h11, 8'h11, 1'b0);
        push_bytes(8'h11, 8'h11, 8);
        chk("single_pre_sync_busy", int'(bus.busy), 0);
        @(posedge CLK);
        #1;
        chk("single_sync_busy", int'(bus.busy), 1);
        chk("single_sync_ctrl", int'(bus.ctrl_logic), 2);
        wait_drain();

        // Partial: 7 bytes never start a frame
        push_bytes(8'h51, 1, 7);
        repeat (30) @(posedge CLK);
        #1;
        chk("partial_busy", int'(bus.busy), 0);
        chk("partial_ctrl", int'(bus.ctrl_logic), 2);
        queue_frame(2, 8'h51, 1, 1'b0);
        push_bytes(8'h58, 1, 1);
        chk("partial_pre_sync_busy", int'(bus.busy), 0);
        @(posedge CLK);
        #1;
        chk("partial_sync_busy", int'(bus.busy), 1);
        wait_drain();

        // Back-to-back with backpressure: 24 bytes, three gapless frames
        queue_frame(2, 8'h30, 1, 1'b0);
        queue_frame(2, 8'h38, 1, 1'b1);
        queue_frame(2, 8'h40, 1, 1'b1);
        push_bytes(8'h30, 1, 24);
        chk("full_in_ready", int'(bus.in_ready), 0);
        wait_drain();

        // mat_dim change at frame cycle 2
        queue_frame(2, 8'h60, 1, 1'b0);
        queue_frame(3, 8'h68, 1, 1'b1);
        fork
            push_bytes(8'h60, 1, 16);
            begin
                wait_busy();
                repeat (2) @(posedge CLK);
                #1;
                bus.mat_dim = 8'd3;
            end
        join
        wait_drain();
        bus.mat_dim = 8'd2;

        // Reset at frame cycle 7
        queue_frame(2, 8'hA0, 1, 1'b0);
        push_bytes(8'hA0, 1, 8);
        wait_busy();
        repeat (7) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        @(posedge CLK);
        #1;
        chk("midrst_ctrl", int'(bus.ctrl_logic), 2);
        chk("midrst_data", int'(bus.data_send), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.frame_done), 0);
        chk("midrst_abandoned", exp_q.size(), 6);
        exp_q.delete();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("midrst_stays_idle", int'(bus.busy), 0);
        queue_frame(2, 8'hC0, 1, 1'b0);
        push_bytes(8'hC0, 1, 8);
        @(posedge CLK);
        #1;
        chk("midrst_fresh_sync", int'(bus.busy), 1);
        wait_drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
